// File: rtl/data_mem_resp.sv
// Data-memory responder for the rysy core load/store port: accepts one byte/half/word
// request at a time, waits WAIT_STATES cycles, then commits to the internal word RAM.
module data_mem_resp #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_sel,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic       ZERO_WAIT = (WAIT_STATES == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic access_err(input logic we, input logic [2:0] sel,
                                        input logic [31:0] addr);
        logic bad;
        case (sel)
            3'b000:  bad = 1'b0;
            3'b100:  bad = we;
            3'b001:  bad = addr[0];
            3'b101:  bad = we | addr[0];
            3'b010:  bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad | ((addr >> ADDR_W) != 32'd0);
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] sel,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (sel)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] sel, input logic [1:0] off);
        logic [3:0] m;
        case (sel[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [2:0]  sel_r;
    logic [31:0] mem_r [DEPTH];

    logic        op_we_s;
    logic [31:0] op_addr_s;
    logic [31:0] op_wdata_s;
    logic [2:0]  op_sel_s;
    logic        enter_resp_s;
    logic        err_s;
    logic [31:0] rdata_s;
    logic [3:0]  be_s;
    logic [31:0] wlanes_s;
    logic [31:0] mem_word_s;

    // Commit operands: with zero wait states the commit edge is the accept edge, so use the live request.
    always_comb begin
        op_we_s    = we_r;
        op_addr_s  = addr_r;
        op_wdata_s = wdata_r;
        op_sel_s   = sel_r;
        if (state_r == ST_IDLE) begin
            op_we_s    = req_we;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
            op_sel_s   = req_sel;
        end else begin
            op_we_s    = we_r;
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
            op_sel_s   = sel_r;
        end

        enter_resp_s = ((state_r == ST_IDLE) && req_valid && ZERO_WAIT) ||
                       ((state_r == ST_WAIT) && (cnt_r == 4'd0));
        mem_word_s   = mem_r[op_addr_s[ADDR_W-1:2]];
        err_s        = access_err(op_we_s, op_sel_s, op_addr_s);
        be_s         = lane_mask(op_sel_s, op_addr_s[1:0]);

        if (err_s || op_we_s) begin
            rdata_s = 32'd0;
        end else begin
            rdata_s = load_extend(mem_word_s, op_sel_s, op_addr_s[1:0]);
        end

        case (op_sel_s[1:0])
            2'b00:   wlanes_s = {4{op_wdata_s[7:0]}};
            2'b01:   wlanes_s = {2{op_wdata_s[15:0]}};
            default: wlanes_s = op_wdata_s;
        endcase
    end

    // RAM lane writes on the commit edge; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp_s && op_we_s && !err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[op_addr_s[ADDR_W-1:2]][8*i +: 8] <= wlanes_s[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM with registered ready/valid and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            we_r       <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            sel_r      <= 3'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        we_r      <= req_we;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        sel_r     <= req_sel;
                        req_ready <= 1'b0;
                        if (ZERO_WAIT) begin
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rdata_s;
                            resp_err   <= err_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_s;
                        resp_err   <= err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the rysy core: the memory-side end of the core's load/store port, serving the byte/half/word requests the control unit issues. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. Stores write the addressed byte lanes; loads return the value sign- or zero-extended. Misaligned or out-of-range accesses are flagged and leave memory unchanged. It sits between the core's memory address mux and a word-organised on-chip RAM, which is held inside this block.

## Interface
Parameters:
- ADDR_W, 12: byte-address bits decoded; RAM depth = 2^(ADDR_W-2) 32-bit words.
- WAIT_STATES, 1: extra cycles between accept and response, 0..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned: byte in [7:0], half in [15:0].
- req_sel  in  3  access type, RISC-V func3 encoding: SB 3'b000, SH 3'b001, SW 3'b010, SBU 3'b100, SHU 3'b101.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: misaligned, out of range, or illegal req_sel.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture we, addr, wdata and sel into registers. Go to WAIT if WAIT_STATES>0, otherwise to RESP.
- WAIT: 4-bit counter loaded with WAIT_STATES-1 at accept and decremented each cycle. At 0 go to RESP.
- The transition into RESP is the commit edge:
  - Stores write the selected lanes.
  - Loads register the extended result.
  - resp_err is registered.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Inputs are ignored outside IDLE.
- Lane select uses addr[1:0]:
  - Byte: lane = addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- Load extension:
  - SB/SH sign-extend from bit 7/15.
  - SBU/SHU zero-extend.
  - SW passes the word through.
- Store sel: SB writes wdata[7:0] to one lane, SH writes wdata[15:0] to two lanes, SW writes all four. SBU/SHU as a store is illegal.
- Error conditions, each setting err=1 with no write and rdata=0:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr >= 2^ADDR_W.
  - req_sel in {3'b011, 3'b110, 3'b111}.
- RAM contents are not cleared by reset and are undefined at power-up. Simulation initialises them to 0.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state IDLE, counter 0.
- Accept occurs at edge E, where req_valid&&req_ready.
  - req_ready drops in cycle E+1.
  - resp_valid is high in cycle E+WAIT_STATES+1.
  - req_ready rises again in cycle E+WAIT_STATES+2.
- Throughput is one transaction per WAIT_STATES+2 cycles.
- resp_rdata and resp_err are valid only while resp_valid=1. They hold their value until the next commit.
- A load issued after a store to the same word sees the new data, since the store commits before the load is accepted.
- rst has priority over everything. If rst is high on the commit edge, no write occurs and no response is produced. rst during WAIT aborts the transaction and returns the block to IDLE next cycle.
- req_valid held high across RESP is not accepted until IDLE. The requester must keep the request stable until req_ready.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10. With WAIT_STATES=1, resp_valid appears 2 cycles after each accept; load returns 0xDEADBEEF, err=0.
- After word 0x10=0xDEADBEEF: SB 0x12 data 0x80, then LB 0x12 -> 0xFFFFFF80, LBU 0x12 -> 0x00000080, LW 0x10 -> 0xDE80BEEF.
- SH 0x16 data 0x8001, then LH 0x16 -> 0xFFFF8001, LHU 0x16 -> 0x00008001, LW 0x14 -> 0x80010000.
- Misaligned and illegal accesses:
  - LW 0x11 -> err=1, rdata=0.
  - SH 0x13 -> err=1, and a later LW 0x10 is unchanged.
  - req_sel=3'b111 -> err=1.
  - Store with SBU -> err=1.
- Out of range: with ADDR_W=12, SW 0x1000 -> err=1, and LW 0x000 is unchanged.
- Reset behaviour:
  - Assert rst during WAIT of an SW (WAIT_STATES=3): no resp_valid, memory unchanged, req_ready=1 the cycle after rst.
  - WAIT_STATES=0: response in cycle E+1.
